// File: rtl/sad_uart_pkg.sv
// Shared types, ASCII constants and the double-dabble step for the SAD result UART.
// Holds no state.
package sad_uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int REC_LEN          = 10;
    localparam int DD_STEPS         = 10;

    localparam logic [7:0] ASCII_M     = 8'h4D;
    localparam logic [7:0] ASCII_N     = 8'h4E;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_LOAD    = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // One shift-add-3 iteration on three BCD digits, shifting in the next binary MSB.
    function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic bin_msb);
        logic [11:0] adj;
        adj = bcd;
        for (int d = 0; d < 3; d++) begin
            if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
        end
        return {adj[10:0], bin_msb};
    endfunction

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'd0, d};
    endfunction

endpackage

// File: rtl/result_uart_tx_if.sv
// Host-side request/result bundle of the result UART: start/match/coords in, txd/busy/sendComplete out.
// Pure wiring, no latency.
interface result_uart_tx_if;
    logic       start;
    logic       match;
    logic [9:0] x_in;
    logic [8:0] y_in;
    logic       txd;
    logic       busy;
    logic       sendComplete;

    modport master (output start, match, x_in, y_in, input txd, busy, sendComplete);
    modport slave  (input start, match, x_in, y_in, output txd, busy, sendComplete);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with its own baud counter; load accepted only while ready.
// Frame lasts 10*CLKS_PER_BIT cycles after the load edge; done is high in the last stop-bit cycle.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       notReset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd,
    output logic       done
);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic        active;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [8:0]  shreg;
    logic        bit_end;

    assign bit_end = active && (baud_cnt == BAUD_LAST);
    assign ready   = !active;
    // Combinational so the parent can reload on the very edge the stop bit ends.
    assign done    = bit_end && (bit_cnt == 4'd9);

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
        end else if (load && !active) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= {1'b1, data};
            txd      <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                    txd    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    txd     <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// Sends the SAD match result as a 10-byte ASCII record "M123,045\r\n" over 8N1 UART.
// sendComplete 1+10+10*(1+10*CLKS_PER_BIT) cycles after start; start ignored unless idle.
module result_uart_tx
    import sad_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clock,
    input  logic              notReset,
    result_uart_tx_if.slave   bus
);
    state_t      state;
    logic        match_lat;
    logic [9:0]  x_lat;
    logic [9:0]  x_sh;
    logic [9:0]  y_sh;
    logic [11:0] x_bcd;
    logic [11:0] y_bcd;
    logic [3:0]  cnv_cnt;
    logic [3:0]  index;
    logic        busy_r;
    logic        done_r;

    logic        byte_load;
    logic [7:0]  byte_dat;
    logic        byte_rdy;
    logic        byte_done;
    logic        txd_int;
    logic [11:0] x_dig;

    assign bus.txd          = txd_int;
    assign bus.busy         = busy_r;
    assign bus.sendComplete = done_r;
    assign byte_load        = (state == ST_LOAD);

    // x beyond three digits saturates; y (9 bit) always fits.
    assign x_dig = (x_lat > 10'd999) ? 12'h999 : x_bcd;

    always_comb begin
        byte_dat = ASCII_LF;
        case (index)
            4'd0:    byte_dat = match_lat ? ASCII_M : ASCII_N;
            4'd1:    byte_dat = digit_ascii(x_dig[11:8]);
            4'd2:    byte_dat = digit_ascii(x_dig[7:4]);
            4'd3:    byte_dat = digit_ascii(x_dig[3:0]);
            4'd4:    byte_dat = ASCII_COMMA;
            4'd5:    byte_dat = digit_ascii(y_bcd[11:8]);
            4'd6:    byte_dat = digit_ascii(y_bcd[7:4]);
            4'd7:    byte_dat = digit_ascii(y_bcd[3:0]);
            4'd8:    byte_dat = ASCII_CR;
            default: byte_dat = ASCII_LF;
        endcase
    end

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state     <= ST_IDLE;
            match_lat <= 1'b0;
            x_lat     <= '0;
            x_sh      <= '0;
            y_sh      <= '0;
            x_bcd     <= '0;
            y_bcd     <= '0;
            cnv_cnt   <= '0;
            index     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        match_lat <= bus.match;
                        x_lat     <= bus.x_in;
                        x_sh      <= bus.x_in;
                        y_sh      <= {1'b0, bus.y_in};
                        x_bcd     <= '0;
                        y_bcd     <= '0;
                        cnv_cnt   <= '0;
                        index     <= '0;
                        busy_r    <= 1'b1;
                        state     <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    x_bcd   <= dd_step(x_bcd, x_sh[9]);
                    y_bcd   <= dd_step(y_bcd, y_sh[9]);
                    x_sh    <= {x_sh[8:0], 1'b0};
                    y_sh    <= {y_sh[8:0], 1'b0};
                    cnv_cnt <= cnv_cnt + 4'd1;
                    if (cnv_cnt == 4'(DD_STEPS - 1)) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (byte_rdy) state <= ST_SEND;
                end
                ST_SEND: begin
                    if (byte_done) begin
                        if (index == 4'(REC_LEN - 1)) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            index <= index + 4'd1;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clock    (clock),
        .notReset (notReset),
        .load     (byte_load),
        .data     (byte_dat),
        .ready    (byte_rdy),
        .txd      (txd_int),
        .done     (byte_done)
    );

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
Reports the final result of a SAD match run to the host PC over the serial line. This is the transmit direction of the UART link that loads image data in.
- On a start pulse it latches the match flag and the best-match coordinates x (10 bit) and y (9 bit).
- It converts both coordinates to 3-digit decimal with a sequential double-dabble converter.
- It sends a fixed 10-byte ASCII record, 8N1, LSB first.
- It sits beside the top-level SAD controller and is triggered when the controller reaches FINISH_MATCH or FINISH_NOTMATCH.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.

Ports:
clock  input  1  system clock; all logic on its rising edge.
notReset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to send a record; sampled only in IDLE.
match  input  1  1 = FINISH_MATCH result, 0 = FINISH_NOTMATCH.
x_in  input  10  best-match x coordinate.
y_in  input  9  best-match y coordinate.
txd  output  1  serial data line; idle high.
busy  output  1  high from the cycle after start is accepted until sendComplete.
sendComplete  output  1  one-cycle pulse when the final stop bit ends.

Behaviour:
- Reset (notReset = 0, asynchronous):
  - outputs: txd = 1, busy = 0, sendComplete = 0.
  - internals: state = IDLE, all counters and latches = 0.
  - Mid-frame reset aborts immediately with no partial-byte completion.
  - After release, the block stays in IDLE until a new start.
- States: IDLE -> CONVERT -> LOAD -> SEND -> (LOAD | DONE) -> IDLE.
- IDLE:
  - txd = 1.
  - On start = 1, latch match, x_in and y_in in the same edge and go to CONVERT.
- CONVERT:
  - Exactly 10 cycles of double-dabble: shift-add-3, MSB first.
  - x and y are converted in parallel; y is zero-extended to 10 bits.
  - If the latched x > 999, the x digits are forced to 9,9,9 (saturate). y max is 511, so y needs no clamp.
- Record byte order (index 0..9):
  - 'M' (0x4D) if match, else 'N' (0x4E).
  - x hundreds, x tens, x units.
  - ',' (0x2C).
  - y hundreds, y tens, y units.
  - CR (0x0D), LF (0x0A).
  - Each digit byte is 0x30 + BCD digit; leading zeros are sent.
- LOAD (1 cycle):
  - Selects byte[index] into the shift register.
  - Clears the bit counter and baud counter.
- SEND:
  - Frame = start bit (0), data bits 0..7 LSB first, stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles, counted by the baud counter (16 bit).
  - After the stop bit: if index < 9, increment index and go to LOAD; otherwise go to DONE.
  - txd is 1 during LOAD, so the inter-byte gap is 1 extra idle cycle.
- DONE (1 cycle): sendComplete = 1, busy falls, return to IDLE.
- Latency from start edge to the sendComplete cycle = 1 + 10 + 10 × (1 + 10 × CLKS_PER_BIT).
- start while busy: ignored, not queued. Latched values are unaffected by input changes after capture.
- start in the same cycle as DONE: ignored. A start is accepted only in the cycle after DONE or later.
- txd is registered, so there are no glitches.

Decomposition:
- Shared package (sad_uart_pkg): state encodings (3 bit), ASCII constants ('M', 'N', ',', CR, LF, '0'), record length 10, default CLKS_PER_BIT.
- One natural sub-module: uart_tx_byte.
  - Function: byte serializer plus baud counter.
  - Interface: load/data/ready handshake in, txd out, done pulse.
  - Its parent, result_uart_tx, holds the FSM, the double-dabble converter and the record mux.

Test Plan:
All tests run with CLKS_PER_BIT = 4; a UART monitor samples each bit at its midpoint.
1. match = 1, x = 123, y = 45, start pulse:
   - bytes 4D 31 32 33 2C 30 34 35 0D 0A.
   - sendComplete exactly 1 + 10 + 10 × 41 = 421 cycles after start.
   - busy high throughout.
2. match = 0, x = 0, y = 511 -> bytes 4E 30 30 30 2C 35 31 31 0D 0A.
3. match = 1, x = 1023, y = 0 -> x saturates: 4D 39 39 39 2C 30 30 30 0D 0A.
4. Extra start pulses at cycles 5 and 200 of a frame, with x_in/y_in changed mid-frame:
   - the record is unchanged.
   - exactly one sendComplete.
   - no second record.
5. Bit timing check: every bit lasts exactly 4 cycles; start bit = 0, stop bit = 1; 1 idle-high cycle between bytes.
6. notReset pulled low during byte 3 bit 5:
   - txd = 1, busy = 0 asynchronously (before the next clock edge).
   - no sendComplete.
   - after release, a new start produces a full correct record.
